rot4_cmd_queue: RTL and testbench



---
 rtl/rot4_cmd_queue.sv | 116 +++++++++++
 tb/tb_rot4_cmd_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rot4_cmd_queue.sv
// Command queue in front of a 4-bit barrel rotator: buffers {amt,data} commands
// and registers the rotator result into an output slot.
// Latency: a command accepted at edge N shows as res_valid after edge N+1. There is no bypass path.
// Backpressure: cmd_ready drops at full and does not look ahead to a same-cycle pop.
//   The result slot holds while res_valid && !res_ready.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake, carrying cmd_data (4b) and cmd_amt (2b)
//   rot_in/rot_sel -> rot_out   external combinational rotator, driven from the head entry
//   res_valid/res_ready         result handshake, carrying res_data (4b)
//   count                       FIFO occupancy, 0..DEPTH
module rot4_cmd_queue #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_data,
  input  logic [1:0]    cmd_amt,
  output logic [3:0]    rot_in,
  output logic [1:0]    rot_sel,
  input  logic [3:0]    rot_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_data,
  output logic [AW:0]   count
);

  // Storage entry layout: {amt[1:0], data[3:0]}.
  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_res_valid;
  logic [3:0]    r_res_data;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_load;
  logic [5:0]    w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready comes from registered occupancy only. A full queue therefore stalls
  // for one cycle even when the head is being consumed on the same edge.
  assign w_push  = cmd_valid && !w_full;

  // The head moves into the slot when the slot is empty or is being drained now.
  assign w_load  = !w_empty && (!r_res_valid || res_ready);

  // The rotator sees the head straight from storage registers. It sees zeros
  // when the queue is empty, so its inputs never carry a stale entry.
  assign w_head  = r_mem[r_rptr];
  assign rot_in  = w_empty ? 4'b0000 : w_head[3:0];
  assign rot_sel = w_empty ? 2'b00   : w_head[5:4];

  assign cmd_ready = !w_full;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign count     = r_count;

  // Storage contents carry no reset. The pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_amt, cmd_data};
    end
  end

  // DEPTH is a power of two, so the natural pointer wrap gives modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_load) r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // On release without a new load, res_data keeps its last value and only the valid bit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 4'b0000;
    end else if (w_load) begin
      r_res_valid <= 1'b1;
      r_res_data  <= rot_out;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Occupancy stays bounded, and the pointer distance agrees with count.
  // At full, the pointers are equal and count is DEPTH.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= (AW+1)'(DEPTH));
  a_ptr_diff : assert property (@(posedge clk) disable iff (!rst_n)
    AW'(r_wptr - r_rptr) == r_count[AW-1:0]);

endmodule

// File: tb/tb_rot4_cmd_queue.sv
module tb_rot4_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [1:0] cmd_amt;
  logic [3:0] rot_in;
  logic [1:0] rot_sel;
  logic [3:0] rot_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  rot4_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
    .rot_in(rot_in), .rot_sel(rot_sel), .rot_out(rot_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External rotator: result bit i = input bit (i+sel) mod 4.
  always_comb begin
    rot_out = 4'b0000;
    for (int i = 0; i < 4; i++) rot_out[i] = rot_in[(i + int'(rot_sel)) % 4];
  end

  // Reference rotate-right, computed by doubling the word and shifting.
  function automatic logic [3:0] rotr(input logic [3:0] d, input logic [1:0] a);
    logic [7:0] w;
    w = {d, d} >> a;
    return w[3:0];
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a queue of pending commands plus one result slot.
  logic [5:0] m_q[$];
  logic       m_v;
  logic [3:0] m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_v = 1'b0;
      m_d = 4'b0000;
    end else begin
      logic do_load;
      logic do_push;
      logic [5:0] head;
      do_load = (m_q.size() != 0) && (!m_v || res_ready);
      do_push = cmd_valid && (m_q.size() != DEPTH);
      if (do_load) begin
        head = m_q.pop_front();
        m_d  = rotr(head[3:0], head[5:4]);
        m_v  = 1'b1;
      end else if (m_v && res_ready) begin
        m_v = 1'b0;
      end
      if (do_push) m_q.push_back({cmd_amt, cmd_data});
    end
  end

  // Every-cycle comparison of all outputs against the model, taken away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] e;
      e = (m_q.size() != 0) ? m_q[0] : 6'd0;
      chk("res_valid", {7'b0, res_valid}, {7'b0, m_v});
      chk("res_data",  {4'b0, res_data},  {4'b0, m_d});
      chk("count",     {5'b0, count},     8'(m_q.size()));
      chk("cmd_ready", {7'b0, cmd_ready}, {7'b0, m_q.size() != DEPTH});
      chk("rot_in",    {4'b0, rot_in},    {4'b0, e[3:0]});
      chk("rot_sel",   {6'b0, rot_sel},   {6'b0, e[5:4]});
    end
  end

  // Record of accepted results, used for hand-computed order checks.
  logic [3:0] got[$];
  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) got.push_back(res_data);
  end

  task automatic step(input logic v, input logic [3:0] d, input logic [1:0] a, input logic rr);
    cmd_valid = v;
    cmd_data  = d;
    cmd_amt   = a;
    res_ready = rr;
    @(negedge clk);
  endtask

  task automatic chk_got(input string nm, input logic [3:0] exp[$]);
    chk({nm, "_len"}, 8'(got.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(nm, {4'b0, got[i]}, {4'b0, exp[i]});
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_res_valid", {7'b0, res_valid}, 8'h00);
    chk("rst_res_data",  {4'b0, res_data},  8'h00);
    chk("rst_count",     {5'b0, count},     8'h00);
    chk("rst_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    chk("rst_rot_in",    {4'b0, rot_in},    8'h00);
    chk("rst_rot_sel",   {6'b0, rot_sel},   8'h00);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_amt = '0; res_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(0, 4'h0, 2'd0, 1); step(0, 4'h0, 2'd0, 1);

    // Asynchronous reset asserted in the middle of a cycle.
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk_reset_vals();
    @(negedge clk); #1;
    rst_n = 1'b1;

    // A single command: (0001, amt 1) gives 1000 one cycle behind acceptance.
    got.delete();
    step(1, 4'b0001, 2'd1, 1);
    chk("single_count_n", {5'b0, count}, 8'd1);
    chk("single_valid_n", {7'b0, res_valid}, 8'd0);
    step(0, 4'h0, 2'd0, 1);
    chk("single_valid_n1", {7'b0, res_valid}, 8'd1);
    chk("single_data_n1", {4'b0, res_data}, 8'b1000);
    chk("single_count_n1", {5'b0, count}, 8'd0);
    step(0, 4'h0, 2'd0, 1);
    chk_got("single", '{4'b1000});

    // Four commands back to back produce four results on consecutive cycles.
    got.delete();
    step(1, 4'b0001, 2'd2, 1);
    step(1, 4'b0001, 2'd3, 1);
    chk("stream_first", {4'b0, res_data}, 8'b0100);
    step(1, 4'b1100, 2'd1, 1);
    step(1, 4'b1100, 2'd2, 1);
    step(0, 4'h0, 2'd0, 1);
    step(0, 4'h0, 2'd0, 1);
    step(0, 4'h0, 2'd0, 1);
    chk_got("stream", '{4'b0100, 4'b0010, 4'b0110, 4'b0011});

    // Fill the queue while the output is stalled, then drain it across the pointer wrap.
    got.delete();
    step(1, 4'b1000, 2'd0, 0);
    step(1, 4'b0011, 2'd1, 0);
    step(1, 4'b0111, 2'd2, 0);
    step(1, 4'b1010, 2'd3, 0);
    step(1, 4'b1110, 2'd1, 0);
    chk("fill_count", {5'b0, count}, 8'd4);
    chk("fill_ready", {7'b0, cmd_ready}, 8'd0);
    chk("fill_data", {4'b0, res_data}, 8'b1000);
    step(1, 4'b1111, 2'd0, 0);
    step(1, 4'b1111, 2'd0, 0);
    chk("fill_hold_data", {4'b0, res_data}, 8'b1000);
    chk("fill_hold_count", {5'b0, count}, 8'd4);
    for (int i = 0; i < 6; i++) step(0, 4'h0, 2'd0, 1);
    chk("drain_count", {5'b0, count}, 8'd0);
    chk_got("drain", '{4'b1000, 4'b1001, 4'b1101, 4'b0101, 4'b0111});

    // A push and a load on the same edge at count=2 leave the count unchanged.
    got.delete();
    step(1, 4'b0001, 2'd0, 0);
    step(1, 4'b0010, 2'd0, 0);
    step(1, 4'b0100, 2'd0, 0);
    chk("simul_pre_count", {5'b0, count}, 8'd2);
    step(1, 4'b1100, 2'd3, 1);
    chk("simul_count", {5'b0, count}, 8'd2);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 2'd0, 1);
    chk_got("simul", '{4'b0001, 4'b0010, 4'b0100, 4'b1001});

    // A reset with queued commands and a held result discards all of them.
    step(1, 4'b0001, 2'd1, 0);
    step(1, 4'b0010, 2'd1, 0);
    step(1, 4'b0100, 2'd1, 0);
    step(1, 4'b1000, 2'd1, 0);
    chk("midrst_pre_count", {5'b0, count}, 8'd3);
    chk("midrst_pre_valid", {7'b0, res_valid}, 8'd1);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    #1 rst_n = 1'b1;
    got.delete();
    @(negedge clk);
    step(1, 4'b0001, 2'd0, 1);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 2'd0, 1);
    chk_got("post_rst", '{4'b0001});

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
